// File: rtl/segment_transition_ctl.sv
// Segment-swap scheduler for one two-segment read datapath (MOD or STM).
// Arms a requested segment switch, fires it on its mode's condition, then counts loops until STOP.
module segment_transition_ctl #(
    parameter int TimeWidth = 64,
    parameter int RepWidth  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 update_settings_i,
    input  logic                 req_rd_segment_i,
    input  logic [7:0]           transition_mode_i,
    input  logic [TimeWidth-1:0] transition_value_i,
    input  logic [RepWidth-1:0]  rep_i,
    input  logic [TimeWidth-1:0] sys_time_i,
    input  logic [3:0]           gpio_in_i,
    input  logic                 loop_end_i,
    output logic                 segment_o,
    output logic                 segment_changed_o,
    output logic                 stop_o,
    output logic                 pending_o,
    output logic                 req_err_o
);

    localparam logic [7:0] ModeSyncIdx = 8'h00;
    localparam logic [7:0] ModeSysTime = 8'h01;
    localparam logic [7:0] ModeGpio    = 8'h02;
    localparam logic [7:0] ModeExt     = 8'hF0;

    typedef enum logic {ST_IDLE, ST_WAIT} state_e;

    state_e                state_q, state_d;
    logic                  seg_q, seg_d;
    logic [7:0]            mode_q, mode_d;
    logic [TimeWidth-1:0]  val_q, val_d;
    logic [RepWidth-1:0]   rep_q, rep_d;
    logic                  gpio_prev_q, gpio_prev_d;
    logic                  segment_q, segment_d;
    logic                  seg_chg_q, seg_chg_d;
    logic                  stop_q, stop_d;
    logic                  req_err_q, req_err_d;
    logic [RepWidth-1:0]   rep_cnt_q, rep_cnt_d;
    logic [RepWidth-1:0]   rep_lim_q, rep_lim_d;

    logic pin_cur;
    logic fire;
    logic mode_known;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            seg_q       <= 1'b0;
            mode_q      <= 8'h00;
            val_q       <= '0;
            rep_q       <= '1;
            gpio_prev_q <= 1'b0;
            segment_q   <= 1'b0;
            seg_chg_q   <= 1'b0;
            stop_q      <= 1'b0;
            req_err_q   <= 1'b0;
            rep_cnt_q   <= '0;
            rep_lim_q   <= '1;
        end else begin
            state_q     <= state_d;
            seg_q       <= seg_d;
            mode_q      <= mode_d;
            val_q       <= val_d;
            rep_q       <= rep_d;
            gpio_prev_q <= gpio_prev_d;
            segment_q   <= segment_d;
            seg_chg_q   <= seg_chg_d;
            stop_q      <= stop_d;
            req_err_q   <= req_err_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_lim_q   <= rep_lim_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        seg_d       = seg_q;
        mode_d      = mode_q;
        val_d       = val_q;
        rep_d       = rep_q;
        segment_d   = segment_q;
        seg_chg_d   = 1'b0;
        stop_d      = stop_q;
        req_err_d   = 1'b0;
        rep_cnt_d   = rep_cnt_q;
        rep_lim_d   = rep_lim_q;
        pin_cur     = gpio_in_i[val_q[1:0]];
        gpio_prev_d = pin_cur;
        fire        = 1'b0;
        mode_known  = 1'b0;

        if (state_q == ST_WAIT) begin
            case (mode_q)
                ModeExt:     fire = 1'b1;
                ModeSyncIdx: fire = loop_end_i | stop_q;
                ModeSysTime: fire = (sys_time_i >= val_q);
                ModeGpio:    fire = pin_cur & ~gpio_prev_q;
                default:     fire = 1'b0;
            endcase
        end

        case (transition_mode_i)
            ModeExt, ModeSyncIdx, ModeSysTime, ModeGpio: mode_known = 1'b1;
            default:                                     mode_known = 1'b0;
        endcase

        // Loop counting for the segment currently playing; a fire below overrides it.
        if (loop_end_i && !stop_q && (rep_lim_q != '1)) begin
            if (rep_cnt_q == rep_lim_q) stop_d = 1'b1;
            else                        rep_cnt_d = rep_cnt_q + 1'b1;
        end

        if (fire) begin
            segment_d = seg_q;
            seg_chg_d = (seg_q != segment_q);
            rep_lim_d = rep_q;
            rep_cnt_d = '0;
            stop_d    = 1'b0;
            state_d   = ST_IDLE;
        end

        // A request coincident with a fire is judged against the post-fire state.
        if (update_settings_i) begin
            if (!mode_known) begin
                req_err_d = 1'b1;
            end else if ((state_d == ST_IDLE) && (req_rd_segment_i == segment_d)) begin
                rep_lim_d = rep_i;
                rep_cnt_d = '0;
                stop_d    = 1'b0;
            end else begin
                seg_d       = req_rd_segment_i;
                mode_d      = transition_mode_i;
                val_d       = transition_value_i;
                rep_d       = rep_i;
                gpio_prev_d = gpio_in_i[transition_value_i[1:0]];
                state_d     = ST_WAIT;
            end
        end
    end

    assign segment_o         = segment_q;
    assign segment_changed_o = seg_chg_q;
    assign stop_o            = stop_q;
    assign pending_o         = (state_q == ST_WAIT);
    assign req_err_o         = req_err_q;

endmodule

// File: tb/tb_segment_transition_ctl.sv
// Directed and random checks of segment_transition_ctl against a loop-count based reference model.
module tb_segment_transition_ctl;

    localparam logic [7:0] M_SYNC = 8'h00;
    localparam logic [7:0] M_TIME = 8'h01;
    localparam logic [7:0] M_GPIO = 8'h02;
    localparam logic [7:0] M_EXT  = 8'hF0;
    localparam logic [7:0] M_BAD  = 8'h07;
    localparam logic [15:0] INF   = 16'hFFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        update_settings_i = 1'b0;
    logic        req_rd_segment_i = 1'b0;
    logic [7:0]  transition_mode_i = 8'h00;
    logic [63:0] transition_value_i = '0;
    logic [15:0] rep_i = '0;
    logic [63:0] sys_time_i = '0;
    logic [3:0]  gpio_in_i = '0;
    logic        loop_end_i = 1'b0;
    logic        segment_o, segment_changed_o, stop_o, pending_o, req_err_o;

    segment_transition_ctl dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .update_settings_i(update_settings_i),
        .req_rd_segment_i(req_rd_segment_i), .transition_mode_i(transition_mode_i),
        .transition_value_i(transition_value_i), .rep_i(rep_i), .sys_time_i(sys_time_i),
        .gpio_in_i(gpio_in_i), .loop_end_i(loop_end_i), .segment_o(segment_o),
        .segment_changed_o(segment_changed_o), .stop_o(stop_o), .pending_o(pending_o),
        .req_err_o(req_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: STOP is derived from loops completed since the last swap/reload.
    bit          m_seg, m_chg, m_stop, m_pend, m_err;
    int          m_loops;
    int          m_lim;
    bit          p_seg, p_prev;
    logic [7:0]  p_mode;
    logic [63:0] p_val;
    int          p_rep;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_seg = 0; m_chg = 0; m_stop = 0; m_pend = 0; m_err = 0;
        m_loops = 0; m_lim = INF;
        p_seg = 0; p_prev = 0; p_mode = 8'h00; p_val = '0; p_rep = INF;
    endtask

    task automatic model_step();
        bit fire;
        bit known;
        fire = 0;
        if (m_pend) begin
            if (p_mode == M_EXT)       fire = 1;
            else if (p_mode == M_SYNC) fire = loop_end_i || m_stop;
            else if (p_mode == M_TIME) fire = (sys_time_i >= p_val);
            else if (p_mode == M_GPIO) fire = gpio_in_i[p_val[1:0]] && !p_prev;
        end
        if (loop_end_i) m_loops++;
        p_prev = gpio_in_i[p_val[1:0]];
        m_chg = 0;
        m_err = 0;
        if (fire) begin
            m_chg = (p_seg != m_seg);
            m_seg = p_seg; m_lim = p_rep; m_loops = 0; m_pend = 0;
        end
        if (update_settings_i) begin
            known = (transition_mode_i inside {M_SYNC, M_TIME, M_GPIO, M_EXT});
            if (!known) m_err = 1;
            else if (!m_pend && req_rd_segment_i == m_seg) begin
                m_lim = rep_i; m_loops = 0;
            end else begin
                p_seg = req_rd_segment_i; p_mode = transition_mode_i;
                p_val = transition_value_i; p_rep = rep_i;
                p_prev = gpio_in_i[transition_value_i[1:0]];
                m_pend = 1;
            end
        end
        m_stop = (m_lim != INF) && (m_loops > m_lim);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
        sys_time_i = sys_time_i + 1;
        check("segment", segment_o, m_seg);
        check("seg_changed", segment_changed_o, m_chg);
        check("stop", stop_o, m_stop);
        check("pending", pending_o, m_pend);
        check("req_err", req_err_o, m_err);
    endtask

    task automatic issue(input bit seg, input logic [7:0] mode, input logic [63:0] val,
                         input logic [15:0] rep);
        update_settings_i = 1; req_rd_segment_i = seg; transition_mode_i = mode;
        transition_value_i = val; rep_i = rep;
        tick();
        update_settings_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 0; update_settings_i = 0; loop_end_i = 0; gpio_in_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_segment", segment_o, 1'b0);
        check("rst_stop", stop_o, 1'b0);
        check("rst_pending", pending_o, 1'b0);
        check("rst_changed", segment_changed_o, 1'b0);
        check("rst_req_err", req_err_o, 1'b0);
        rst_ni = 1;
    endtask

    initial begin
        int k_swap, k_stop;
        logic [63:0] t_obs;
        logic [7:0] modes [5];
        modes = '{M_SYNC, M_TIME, M_GPIO, M_EXT, M_BAD};

        do_reset();

        // EXT: swap two cycles after the request, infinite repetition never stops
        issue(1, M_EXT, 0, INF);
        check("ext_t1_seg", segment_o, 1'b0);
        tick();
        check("ext_t2_seg", segment_o, 1'b1);
        check("ext_t2_chg", segment_changed_o, 1'b1);
        for (int k = 0; k < 20; k++) begin
            loop_end_i = k[0];
            tick();
        end
        loop_end_i = 0;
        check("ext_inf_stop", stop_o, 1'b0);

        // SYNC_IDX with REP=2, loop end every 16 cycles
        do_reset();
        issue(1, M_SYNC, 0, 16'd2);
        k_swap = -1; k_stop = -1;
        for (int k = 0; k < 72; k++) begin
            loop_end_i = (k % 16 == 15);
            tick();
            if (segment_o && k_swap < 0) k_swap = k;
            if (stop_o && k_stop < 0) k_stop = k;
        end
        loop_end_i = 0;
        check("sync_swap_cycle", k_swap, 15);
        check("sync_stop_cycle", k_stop, 63);

        // SYS_TIME: future target, then a target already in the past
        do_reset();
        sys_time_i = 900;
        issue(1, M_TIME, 1000, INF);
        t_obs = '0;
        for (int k = 0; k < 300 && t_obs == 0; k++) begin
            tick();
            if (segment_o) t_obs = sys_time_i;
        end
        check("time_swap_at", t_obs, 64'd1001);
        sys_time_i = 2000;
        issue(0, M_TIME, 1000, INF);
        check("time_past_t1", segment_o, 1'b1);
        tick();
        check("time_past_t2", segment_o, 1'b0);

        // GPIO: pin already high does not fire; a fresh rising edge does
        gpio_in_i = 4'b0100;
        issue(1, M_GPIO, 2, INF);
        repeat (4) tick();
        check("gpio_high_hold", segment_o, 1'b0);
        check("gpio_high_pend", pending_o, 1'b1);
        gpio_in_i = 4'b0000;
        repeat (2) tick();
        gpio_in_i = 4'b0100;
        tick();
        check("gpio_rise_seg", segment_o, 1'b1);

        // Last request wins: EXT replaces a pending far SYS_TIME request
        issue(0, M_TIME, sys_time_i + 100, INF);
        repeat (3) tick();
        issue(0, M_EXT, 0, INF);
        tick();
        check("replace_seg", segment_o, 1'b0);
        check("replace_pend", pending_o, 1'b0);

        // Unknown mode, then asynchronous reset while waiting
        issue(1, M_EXT, 0, INF);
        tick();
        issue(0, M_TIME, sys_time_i + 500, INF);
        tick();
        issue(1, M_BAD, 0, INF);
        check("bad_err", req_err_o, 1'b1);
        check("bad_seg", segment_o, 1'b1);
        check("bad_pend", pending_o, 1'b1);
        #3;
        rst_ni = 0;
        #1;
        check("async_pend", pending_o, 1'b0);
        check("async_seg", segment_o, 1'b0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1;

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            update_settings_i = ($urandom_range(0, 6) == 0);
            req_rd_segment_i  = 1'($urandom_range(0, 1));
            transition_mode_i = modes[$urandom_range(0, 4)];
            rep_i = ($urandom_range(0, 3) == 0) ? INF : 16'($urandom_range(0, 3));
            if (transition_mode_i == M_TIME)
                transition_value_i = sys_time_i + 64'($urandom_range(0, 60)) - 64'd20;
            else
                transition_value_i = 64'($urandom_range(0, 3));
            loop_end_i = ($urandom_range(0, 5) == 0);
            gpio_in_i  = 4'($urandom_range(0, 15));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
